// File: rtl/iter_multiplier_if.sv
// Handshake and operand/result bundle for the iterative multiplier.
// The master issues operations; the slave (the multiplier) returns results and status.
interface iter_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             flush;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ret_lo;
  logic [WIDTH-1:0] ret_hi;
  logic             n_flag;
  logic             z_flag;

  modport master (
    output start, cmd, a, b, c, d, flush,
    input  ready, busy, done, ret_lo, ret_hi, n_flag, z_flag
  );

  modport slave (
    input  start, cmd, a, b, c, d, flush,
    output ready, busy, done, ret_lo, ret_hi, n_flag, z_flag
  );
endinterface

// File: rtl/iter_multiplier.sv
// Multi-cycle shift-add multiplier for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
// Retires RADIX multiplier bits per RUN cycle, then applies sign and accumulate in FIX.
module iter_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADIX = 2
) (
  input  logic            clk,
  input  logic            reset,
  iter_multiplier_if.slave bus
);
  localparam int unsigned STEPS = WIDTH / RADIX;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  generate
    if (!((RADIX == 1) || (RADIX == 2) || (RADIX == 4)) || ((WIDTH % RADIX) != 0)) begin : g_bad_param
      $error("iter_multiplier: RADIX must be 1, 2 or 4 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state;
  logic [2:0]       cmd_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    mcand;
  logic [PW-1:0]    prod;
  logic             neg;
  logic [CNT_W-1:0] count;

  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] ret_lo_q;
  logic [WIDTH-1:0] ret_hi_q;
  logic             n_q;
  logic             z_q;

  logic             signed_long_c;
  logic [WIDTH-1:0] a_abs_c;
  logic [WIDTH-1:0] b_abs_c;
  logic [PW-1:0]    pp_c;
  logic [PW-1:0]    p_c;
  logic [PW-1:0]    long_c;
  logic [WIDTH-1:0] short_lo_c;

  // Operand conditioning at accept; |most-negative| wraps to 2^(WIDTH-1), which is correct as unsigned.
  always_comb begin
    signed_long_c = bus.cmd[2] & bus.cmd[1];
    a_abs_c = bus.a[WIDTH-1] ? ((~bus.a) + WIDTH'(1)) : bus.a;
    b_abs_c = bus.b[WIDTH-1] ? ((~bus.b) + WIDTH'(1)) : bus.b;
  end

  // Partial product for the RADIX low multiplier bits; mcand is already pre-shifted.
  always_comb begin
    pp_c = '0;
    for (int i = 0; i < int'(RADIX); i++) begin
      if (mplier[i]) begin
        pp_c = pp_c + (mcand << i);
      end
    end
  end

  // Sign correction and accumulate, used only in FIX.
  always_comb begin
    p_c        = neg ? ((~prod) + PW'(1)) : prod;
    long_c     = p_c + (cmd_q[0] ? {d_q, c_q} : PW'(0));
    short_lo_c = p_c[WIDTH-1:0] + (cmd_q[0] ? c_q : WIDTH'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cmd_q    <= '0;
      c_q      <= '0;
      d_q      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      count    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ret_lo_q <= '0;
      ret_hi_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else if (bus.flush) begin
      // Abort: same as reset but the last result stays visible.
      state    <= S_IDLE;
      cmd_q    <= '0;
      c_q      <= '0;
      d_q      <= '0;
      mplier   <= '0;
      mcand    <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      count    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            cmd_q   <= bus.cmd;
            c_q     <= bus.c;
            d_q     <= bus.d;
            mcand   <= {WIDTH'(0), signed_long_c ? a_abs_c : bus.a};
            mplier  <= signed_long_c ? b_abs_c : bus.b;
            neg     <= signed_long_c & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            prod    <= '0;
            count   <= CNT_W'(STEPS);
            state   <= S_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          prod   <= prod + pp_c;
          mcand  <= mcand << RADIX;
          mplier <= mplier >> RADIX;
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (cmd_q[2]) begin
            ret_lo_q <= long_c[WIDTH-1:0];
            ret_hi_q <= long_c[PW-1:WIDTH];
            n_q      <= long_c[PW-1];
            z_q      <= (long_c == PW'(0));
          end else begin
            ret_lo_q <= short_lo_c;
            ret_hi_q <= '0;
            n_q      <= short_lo_c[WIDTH-1];
            z_q      <= (short_lo_c == WIDTH'(0));
          end
          state   <= S_DONE;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ret_lo = ret_lo_q;
  assign bus.ret_hi = ret_hi_q;
  assign bus.n_flag = n_q;
  assign bus.z_flag = z_q;
endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench for iter_multiplier: RADIX=2 main instance plus RADIX=1/4 instances for latency.
// Latency is counted in rising edges, the accept edge being edge 1.
module tb_iter_multiplier;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iter_multiplier_if #(.WIDTH(W)) bus2 ();
  iter_multiplier_if #(.WIDTH(W)) bus1 ();
  iter_multiplier_if #(.WIDTH(W)) bus4 ();

  iter_multiplier #(.WIDTH(W), .RADIX(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  iter_multiplier #(.WIDTH(W), .RADIX(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  iter_multiplier #(.WIDTH(W), .RADIX(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus1.start = bus2.start;  assign bus4.start = bus2.start;
  assign bus1.cmd   = bus2.cmd;    assign bus4.cmd   = bus2.cmd;
  assign bus1.a     = bus2.a;      assign bus4.a     = bus2.a;
  assign bus1.b     = bus2.b;      assign bus4.b     = bus2.b;
  assign bus1.c     = bus2.c;      assign bus4.c     = bus2.c;
  assign bus1.d     = bus2.d;      assign bus4.d     = bus2.d;
  assign bus1.flush = bus2.flush;  assign bus4.flush = bus2.flush;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
  } exp_t;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];
  exp_t last;

  function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi, input logic n, input logic z);
    exp_t e;
    e.lo = lo; e.hi = hi; e.n = n; e.z = z;
    return e;
  endfunction

  // Reference model using native wide arithmetic.
  function automatic exp_t model(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d);
    logic [63:0] xa, xb, p, r;
    logic [31:0] lo;
    if (cmd[2]) begin
      if (cmd[1]) begin
        xa = {{32{a[31]}}, a};
        xb = {{32{b[31]}}, b};
      end else begin
        xa = {32'd0, a};
        xb = {32'd0, b};
      end
      p = xa * xb;
      r = p + (cmd[0] ? {d, c} : 64'd0);
      return mk(r[31:0], r[63:32], r[63], r == 64'd0);
    end
    lo = a * b + (cmd[0] ? c : 32'd0);
    return mk(lo, 32'd0, lo[31], lo == 32'd0);
  endfunction

  function automatic exp_t observed();
    return mk(bus2.ret_lo, bus2.ret_hi, bus2.n_flag, bus2.z_flag);
  endfunction

  task automatic drive_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
    bus2.cmd = cmd; bus2.a = a; bus2.b = b; bus2.c = c; bus2.d = d;
    bus2.start = 1'b1;
  endtask

  // Called on the negedge right after the accept edge (k=1); returns the edge count at done.
  task automatic wait_done(inout int k);
    while (bus2.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus2.flush = 1'b0;
    bus2.start = 1'b0;
    drive_op(3'b000, 32'd0, 32'd0, 32'd0, 32'd0);
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus2.ready, bus2.busy, bus2.done} !== 3'b100)
      $display("FAIL reset_ctrl: ready/busy/done=%b want 100", {bus2.ready, bus2.busy, bus2.done});
    else passed++;
    total++;
    if (observed() !== mk(32'd0, 32'd0, 1'b0, 1'b0))
      $display("FAIL reset_ret: lo=%h hi=%h n=%b z=%b want all zero", bus2.ret_lo, bus2.ret_hi, bus2.n_flag, bus2.z_flag);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_radix();
    int k1 = 0, k2 = 0, k4 = 0;
    exp_t e;
    sb.push_back(mk(32'd42, 32'd0, 1'b0, 1'b0));
    drive_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0);
    @(negedge clk);
    bus2.start = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (bus1.done === 1'b1 && k1 == 0) begin
        k1 = i;
        total++;
        if (bus1.ret_lo !== 32'd42 || bus1.ret_hi !== 32'd0)
          $display("FAIL r1_result: got %h_%h want 00000000_0000002a", bus1.ret_hi, bus1.ret_lo);
        else passed++;
      end
      if (bus4.done === 1'b1 && k4 == 0) begin
        k4 = i;
        total++;
        if (bus4.ret_lo !== 32'd42 || bus4.ret_hi !== 32'd0)
          $display("FAIL r4_result: got %h_%h want 00000000_0000002a", bus4.ret_hi, bus4.ret_lo);
        else passed++;
      end
      if (bus2.done === 1'b1 && k2 == 0) begin
        k2 = i;
        e = sb.pop_front();
        last = e;
        total++;
        if (observed() !== e)
          $display("FAIL mul_result: got %h want %h", observed(), e);
        else passed++;
      end
      if (i < 60) @(negedge clk);
    end
    total++;
    if (k2 != 18) $display("FAIL r2_latency: got %0d want 18", k2); else passed++;
    total++;
    if (k1 != 34) $display("FAIL r1_latency: got %0d want 34", k1); else passed++;
    total++;
    if (k4 != 10) $display("FAIL r4_latency: got %0d want 10", k4); else passed++;
  endtask

  task automatic test_long();
    logic [2:0]  tc[9];
    logic [31:0] ta[9], tb_[9], tcc[9], td[9];
    exp_t        te[9];
    logic [2:0]  cmds[6];
    int k;
    exp_t e;
    tc[0] = 3'b100; ta[0] = 32'hFFFFFFFF; tb_[0] = 32'hFFFFFFFF; tcc[0] = 0; td[0] = 0;
    te[0] = mk(32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0);
    tc[1] = 3'b110; ta[1] = 32'hFFFFFFFE; tb_[1] = 32'd3; tcc[1] = 0; td[1] = 0;
    te[1] = mk(32'hFFFFFFFA, 32'hFFFFFFFF, 1'b1, 1'b0);
    tc[2] = 3'b110; ta[2] = 32'h80000000; tb_[2] = 32'h80000000; tcc[2] = 0; td[2] = 0;
    te[2] = mk(32'h00000000, 32'h40000000, 1'b0, 1'b0);
    tc[3] = 3'b101; ta[3] = 32'hFFFFFFFF; tb_[3] = 32'd1; tcc[3] = 32'hFFFFFFFF; td[3] = 0;
    te[3] = mk(32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    tc[4] = 3'b111; ta[4] = 32'hFFFFFFFF; tb_[4] = 32'hFFFFFFFF; tcc[4] = 32'hFFFFFFFF; td[4] = 32'hFFFFFFFF;
    te[4] = mk(32'h00000000, 32'h00000000, 1'b0, 1'b1);
    tc[5] = 3'b001; ta[5] = 32'd3; tb_[5] = 32'd5; tcc[5] = 32'd10; td[5] = 32'hDEADBEEF;
    te[5] = mk(32'd25, 32'd0, 1'b0, 1'b0);
    tc[6] = 3'b010; ta[6] = 32'hFFFFFFFE; tb_[6] = 32'd3; tcc[6] = 0; td[6] = 0;
    te[6] = mk(32'hFFFFFFFA, 32'd0, 1'b1, 1'b0);
    tc[7] = 3'b000; ta[7] = 32'h00010000; tb_[7] = 32'h00010000; tcc[7] = 0; td[7] = 0;
    te[7] = mk(32'd0, 32'd0, 1'b0, 1'b1);
    tc[8] = 3'b110; ta[8] = 32'h80000000; tb_[8] = 32'd1; tcc[8] = 0; td[8] = 0;
    te[8] = mk(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    cmds[0] = 3'b000; cmds[1] = 3'b001; cmds[2] = 3'b100;
    cmds[3] = 3'b101; cmds[4] = 3'b110; cmds[5] = 3'b111;
    for (int i = 0; i < 9 + 8; i++) begin
      if (i < 9) begin
        sb.push_back(te[i]);
        drive_op(tc[i], ta[i], tb_[i], tcc[i], td[i]);
      end else begin
        logic [2:0]  rc;
        logic [31:0] ra, rb, rcc, rd;
        rc = cmds[$urandom_range(0, 5)];
        ra = $urandom; rb = $urandom; rcc = $urandom; rd = $urandom;
        sb.push_back(model(rc, ra, rb, rcc, rd));
        drive_op(rc, ra, rb, rcc, rd);
      end
      @(negedge clk);
      bus2.start = 1'b0;
      k = 1;
      wait_done(k);
      total++;
      if (k != 18 || bus2.done !== 1'b1)
        $display("FAIL op%0d_latency: got %0d done=%b want 18 done=1", i, k, bus2.done);
      else passed++;
      e = sb.pop_front();
      last = e;
      total++;
      if (observed() !== e)
        $display("FAIL op%0d_result: got lo=%h hi=%h n=%b z=%b want lo=%h hi=%h n=%b z=%b", i,
                 bus2.ret_lo, bus2.ret_hi, bus2.n_flag, bus2.z_flag, e.lo, e.hi, e.n, e.z);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int extra = 0;
    exp_t e;
    sb.push_back(model(3'b100, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0));
    drive_op(3'b100, 32'h12345678, 32'h9ABCDEF0, 32'd0, 32'd0);
    @(negedge clk);
    drive_op(3'b111, 32'hFFFFFFFB, 32'd7, 32'd100, 32'd0);
    k = 1;
    wait_done(k);
    total++;
    if (k != 18 || bus2.ready !== 1'b1)
      $display("FAIL held_start_first: got k=%0d ready=%b want 18 ready=1", k, bus2.ready);
    else passed++;
    e = sb.pop_front();
    total++;
    if (observed() !== e)
      $display("FAIL held_start_result: got %h want %h", observed(), e);
    else passed++;
    sb.push_back(model(3'b111, 32'hFFFFFFFB, 32'd7, 32'd100, 32'd0));
    @(negedge clk);
    bus2.start = 1'b0;
    total++;
    if ({bus2.done, bus2.busy, bus2.ready} !== 3'b010)
      $display("FAIL b2b_accept: done/busy/ready=%b want 010", {bus2.done, bus2.busy, bus2.ready});
    else passed++;
    k = 1;
    wait_done(k);
    total++;
    if (k != 18) $display("FAIL b2b_latency: got %0d want 18", k); else passed++;
    e = sb.pop_front();
    last = e;
    total++;
    if (observed() !== e)
      $display("FAIL b2b_result: got %h want %h", observed(), e);
    else passed++;
    repeat (30) begin
      @(negedge clk);
      if (bus2.done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) $display("FAIL b2b_extra_done: got %0d want 0", extra); else passed++;
  endtask

  task automatic test_abort(input bit use_reset);
    int dones = 0;
    drive_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0);
    @(negedge clk);
    bus2.start = 1'b0;
    repeat (4) @(negedge clk);
    if (use_reset) reset = 1'b1; else bus2.flush = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus2.flush = 1'b0;
    total++;
    if ({bus2.ready, bus2.busy, bus2.done} !== 3'b100)
      $display("FAIL abort%0d_ctrl: ready/busy/done=%b want 100", use_reset, {bus2.ready, bus2.busy, bus2.done});
    else passed++;
    if (use_reset) last = mk(32'd0, 32'd0, 1'b0, 1'b0);
    total++;
    if (observed() !== last)
      $display("FAIL abort%0d_ret: got %h want %h", use_reset, observed(), last);
    else passed++;
    repeat (30) begin
      @(negedge clk);
      if (bus2.done === 1'b1) dones++;
    end
    total++;
    if (dones != 0) $display("FAIL abort%0d_no_done: got %0d want 0", use_reset, dones); else passed++;
  endtask

  initial begin
    test_reset();
    test_mul_radix();
    test_long();
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
